// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory arbiter slice.
// Holds the RV32 load/store size codes, the requester identifiers and the lane count.
package dmem_pkg;

    localparam int unsigned NUM_LANES = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DMA  = 1'b1
    } req_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane handling for one access: store mask and replication,
// load extraction with sign/zero extension, and misalign/illegal detection.
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic                 we,
    input  logic [2:0]           funct3,
    input  logic [1:0]           addr_lo,
    input  logic [DW-1:0]        wdata,
    input  logic [DW-1:0]        rdata_word,
    output logic [NUM_LANES-1:0] mask,
    output logic [DW-1:0]        wdata_lanes,
    output logic [DW-1:0]        rdata_ext,
    output logic                 misaligned,
    output logic                 illegal
);

    localparam int unsigned LW = DW / NUM_LANES;

    logic [NUM_LANES-1:0] base_mask;
    logic [DW-1:0]        shifted;
    logic [LW-1:0]        lane_b;
    logic [2*LW-1:0]      lane_h;

    assign shifted = rdata_word >> (LW * int'(addr_lo));
    assign lane_b  = shifted[LW-1:0];
    assign lane_h  = shifted[2*LW-1:0];

    always_comb begin
        base_mask   = '0;
        wdata_lanes = wdata;
        misaligned  = 1'b0;
        illegal     = 1'b0;
        rdata_ext   = '0;
        case (funct3)
            F3_B: begin
                base_mask   = 4'b0001;
                wdata_lanes = {NUM_LANES{wdata[LW-1:0]}};
                rdata_ext   = {{(DW-LW){lane_b[LW-1]}}, lane_b};
            end
            F3_H: begin
                base_mask   = 4'b0011;
                wdata_lanes = {2{wdata[2*LW-1:0]}};
                misaligned  = addr_lo[0];
                rdata_ext   = {{(DW-2*LW){lane_h[2*LW-1]}}, lane_h};
            end
            F3_W: begin
                base_mask  = 4'b1111;
                misaligned = (addr_lo != 2'b00);
                rdata_ext  = rdata_word;
            end
            F3_BU: begin
                illegal   = we;
                rdata_ext = {{(DW-LW){1'b0}}, lane_b};
            end
            F3_HU: begin
                misaligned = addr_lo[0];
                illegal    = we;
                rdata_ext  = {{(DW-2*LW){1'b0}}, lane_h};
            end
            default: illegal = 1'b1;
        endcase

        // Stores and faulted accesses return zero data; faults never write.
        if (we || misaligned || illegal) begin
            rdata_ext = '0;
        end
        mask = (we && !misaligned && !illegal) ? (base_mask << addr_lo) : '0;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester (core, DMA) round-robin arbiter in front of a single-port data memory,
// issuing one access per cycle and returning a registered response one cycle later.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter  int unsigned DW             = 32,
    parameter  int unsigned MEM_SIZE_IN_KB = 1,
    localparam int unsigned BADDRW         = $clog2(MEM_SIZE_IN_KB * 1024)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 core_req_i,
    input  logic                 core_we_i,
    input  logic [2:0]           core_funct3_i,
    input  logic [BADDRW-1:0]    core_addr_i,
    input  logic [DW-1:0]        core_wdata_i,
    output logic                 core_gnt_o,
    output logic                 core_rsp_valid_o,
    output logic                 core_rsp_err_o,
    output logic [DW-1:0]        core_rdata_o,

    input  logic                 dma_req_i,
    input  logic                 dma_we_i,
    input  logic [2:0]           dma_funct3_i,
    input  logic [BADDRW-1:0]    dma_addr_i,
    input  logic [DW-1:0]        dma_wdata_i,
    output logic                 dma_gnt_o,
    output logic                 dma_rsp_valid_o,
    output logic                 dma_rsp_err_o,
    output logic [DW-1:0]        dma_rdata_o,

    output logic                 mem_cs_o,
    output logic                 mem_we_o,
    output logic [NUM_LANES-1:0] mem_mask_o,
    output logic [BADDRW-3:0]    mem_addr_o,
    output logic [DW-1:0]        mem_wdata_o,
    input  logic [DW-1:0]        mem_rdata_i
);

    req_e prio_q, prio_d;

    logic              any_gnt;
    logic              sel_we;
    logic [2:0]        sel_funct3;
    logic [BADDRW-1:0] sel_addr;
    logic [DW-1:0]     sel_wdata;

    logic [NUM_LANES-1:0] lane_mask;
    logic [DW-1:0]        lane_wdata;
    logic [DW-1:0]        lane_rdata;
    logic                 misaligned;
    logic                 illegal;
    logic                 acc_err;
    logic                 issue;

    logic          core_valid_q, core_valid_d;
    logic          core_err_q, core_err_d;
    logic [DW-1:0] core_rdata_q, core_rdata_d;
    logic          dma_valid_q, dma_valid_d;
    logic          dma_err_q, dma_err_d;
    logic [DW-1:0] dma_rdata_q, dma_rdata_d;

    // A lone requester always wins; a tie goes to whoever the pointer favours.
    assign core_gnt_o = !rst_i && core_req_i && (!dma_req_i || (prio_q == REQ_CORE));
    assign dma_gnt_o  = !rst_i && dma_req_i && (!core_req_i || (prio_q == REQ_DMA));
    assign any_gnt    = core_gnt_o || dma_gnt_o;

    assign sel_we     = dma_gnt_o ? dma_we_i     : core_we_i;
    assign sel_funct3 = dma_gnt_o ? dma_funct3_i : core_funct3_i;
    assign sel_addr   = dma_gnt_o ? dma_addr_i   : core_addr_i;
    assign sel_wdata  = dma_gnt_o ? dma_wdata_i  : core_wdata_i;

    dmem_lane_align #(
        .DW(DW)
    ) u_lane_align (
        .we          (sel_we),
        .funct3      (sel_funct3),
        .addr_lo     (sel_addr[1:0]),
        .wdata       (sel_wdata),
        .rdata_word  (mem_rdata_i),
        .mask        (lane_mask),
        .wdata_lanes (lane_wdata),
        .rdata_ext   (lane_rdata),
        .misaligned  (misaligned),
        .illegal     (illegal)
    );

    assign acc_err = misaligned || illegal;
    assign issue   = any_gnt && !acc_err;

    assign mem_cs_o    = issue;
    assign mem_we_o    = issue && sel_we;
    assign mem_mask_o  = issue ? lane_mask : '0;
    assign mem_addr_o  = sel_addr[BADDRW-1:2];
    assign mem_wdata_o = lane_wdata;

    always_comb begin
        prio_d       = prio_q;
        core_valid_d = core_gnt_o;
        core_err_d   = core_gnt_o && acc_err;
        core_rdata_d = core_gnt_o ? lane_rdata : '0;
        dma_valid_d  = dma_gnt_o;
        dma_err_d    = dma_gnt_o && acc_err;
        dma_rdata_d  = dma_gnt_o ? lane_rdata : '0;
        if (any_gnt) begin
            prio_d = dma_gnt_o ? REQ_CORE : REQ_DMA;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q       <= REQ_CORE;
            core_valid_q <= 1'b0;
            core_err_q   <= 1'b0;
            core_rdata_q <= '0;
            dma_valid_q  <= 1'b0;
            dma_err_q    <= 1'b0;
            dma_rdata_q  <= '0;
        end else begin
            prio_q       <= prio_d;
            core_valid_q <= core_valid_d;
            core_err_q   <= core_err_d;
            core_rdata_q <= core_rdata_d;
            dma_valid_q  <= dma_valid_d;
            dma_err_q    <= dma_err_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    // Reset arriving right after a grant suppresses the already-registered response.
    assign core_rsp_valid_o = core_valid_q && !rst_i;
    assign core_rsp_err_o   = core_err_q && !rst_i;
    assign core_rdata_o     = rst_i ? '0 : core_rdata_q;
    assign dma_rsp_valid_o  = dma_valid_q && !rst_i;
    assign dma_rsp_err_o    = dma_err_q && !rst_i;
    assign dma_rdata_o      = rst_i ? '0 : dma_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table plus directed arbitration/reset
// sequences, with responses checked against a per-cycle expectation queue.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int unsigned DW     = 32;
    localparam int unsigned BADDRW = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              core_req, core_we, core_gnt, core_rsp_valid, core_rsp_err;
    logic [2:0]        core_funct3;
    logic [BADDRW-1:0] core_addr;
    logic [DW-1:0]     core_wdata, core_rdata;
    logic              dma_req, dma_we, dma_gnt, dma_rsp_valid, dma_rsp_err;
    logic [2:0]        dma_funct3;
    logic [BADDRW-1:0] dma_addr;
    logic [DW-1:0]     dma_wdata, dma_rdata;
    logic              mem_cs, mem_we;
    logic [3:0]        mem_mask;
    logic [BADDRW-3:0] mem_addr;
    logic [DW-1:0]     mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .DW             (DW),
        .MEM_SIZE_IN_KB (1)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .core_req_i       (core_req),
        .core_we_i        (core_we),
        .core_funct3_i    (core_funct3),
        .core_addr_i      (core_addr),
        .core_wdata_i     (core_wdata),
        .core_gnt_o       (core_gnt),
        .core_rsp_valid_o (core_rsp_valid),
        .core_rsp_err_o   (core_rsp_err),
        .core_rdata_o     (core_rdata),
        .dma_req_i        (dma_req),
        .dma_we_i         (dma_we),
        .dma_funct3_i     (dma_funct3),
        .dma_addr_i       (dma_addr),
        .dma_wdata_i      (dma_wdata),
        .dma_gnt_o        (dma_gnt),
        .dma_rsp_valid_o  (dma_rsp_valid),
        .dma_rsp_err_o    (dma_rsp_err),
        .dma_rdata_o      (dma_rdata),
        .mem_cs_o         (mem_cs),
        .mem_we_o         (mem_we),
        .mem_mask_o       (mem_mask),
        .mem_addr_o       (mem_addr),
        .mem_wdata_o      (mem_wdata),
        .mem_rdata_i      (mem_rdata)
    );

    // Memory model: combinational read, lane-masked write on the clock edge.
    logic [DW-1:0] mem [256];
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_cs && mem_we) begin
            for (int l = 0; l < 4; l++) begin
                if (mem_mask[l]) mem[mem_addr][8*l +: 8] <= mem_wdata[8*l +: 8];
            end
        end
    end

    typedef struct packed {
        logic              we;
        logic [2:0]        f3;
        logic [BADDRW-1:0] addr;
        logic [DW-1:0]     wdata;
    } acc_t;

    typedef struct packed {
        acc_t       acc;
        logic [3:0] mask;
        logic [7:0] maddr;
        logic [31:0] mwdata;
        logic       err;
        logic [31:0] rdata;
    } vec_t;

    typedef struct packed {
        logic        cv;
        logic        ce;
        logic [31:0] cd;
        logic        dv;
        logic        de;
        logic [31:0] dd;
    } rsp_t;

    rsp_t exp_q[$];
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errs   = 0;
    logic exp_prio = 1'b0;  // 0 favours core, 1 favours DMA
    logic eg_c, eg_d;

    function automatic acc_t mk(input logic we, input logic [2:0] f3,
                                input logic [BADDRW-1:0] addr, input logic [31:0] wdata);
        acc_t a;
        a.we = we; a.f3 = f3; a.addr = addr; a.wdata = wdata;
        return a;
    endfunction

    function automatic vec_t mkv(input acc_t a, input logic [3:0] mask, input logic [7:0] maddr,
                                 input logic [31:0] mwdata, input logic err,
                                 input logic [31:0] rdata);
        vec_t v;
        v.acc = a; v.mask = mask; v.maddr = maddr; v.mwdata = mwdata;
        v.err = err; v.rdata = rdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle's inputs, checks grants and the response due this cycle,
    // and queues the response expected next cycle. Returns mid-cycle.
    task automatic begin_cycle(input logic r, input logic creq, input acc_t c,
                               input logic dreq, input acc_t d,
                               input logic exp_err, input logic [31:0] exp_rdata);
        rsp_t e, act;
        rst = r;
        core_req = creq; core_we = c.we; core_funct3 = c.f3;
        core_addr = c.addr; core_wdata = c.wdata;
        dma_req = dreq; dma_we = d.we; dma_funct3 = d.f3;
        dma_addr = d.addr; dma_wdata = d.wdata;
        #1;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        if (r) e = '0;
        act = {core_rsp_valid, core_rsp_err, core_rdata, dma_rsp_valid, dma_rsp_err, dma_rdata};
        check("rsp", 72'(act), 72'(e));

        eg_c = !r && creq && (!dreq || !exp_prio);
        eg_d = !r && dreq && (!creq || exp_prio);
        check("gnt", 72'({core_gnt, dma_gnt}), 72'({eg_c, eg_d}));
        if (eg_c || eg_d) check("cs", 72'(mem_cs), 72'(!exp_err));
        else check("idle_mem", 72'({mem_cs, mem_we, mem_mask}), 72'(0));

        e = '0;
        if (eg_c) begin e.cv = 1'b1; e.ce = exp_err; e.cd = exp_rdata; end
        if (eg_d) begin e.dv = 1'b1; e.de = exp_err; e.dd = exp_rdata; end
        exp_q.push_back(e);

        if (r) exp_prio = 1'b0;
        else if (eg_c) exp_prio = 1'b1;
        else if (eg_d) exp_prio = 1'b0;
    endtask

    task automatic end_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input logic r, input logic creq, input acc_t c,
                         input logic dreq, input acc_t d,
                         input logic exp_err, input logic [31:0] exp_rdata);
        begin_cycle(r, creq, c, dreq, d, exp_err, exp_rdata);
        end_cycle();
    endtask

    acc_t idle;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        idle = mk(1'b0, F3_W, 10'h000, 32'h0);

        vecs.push_back(mkv(mk(1, F3_W,  10'h010, 32'hDEADBEEF), 4'b1111, 8'h04, 32'hDEADBEEF, 0, 32'h0));
        vecs.push_back(mkv(mk(1, F3_W,  10'h020, 32'h80FF7F01), 4'b1111, 8'h08, 32'h80FF7F01, 0, 32'h0));
        vecs.push_back(mkv(mk(0, F3_B,  10'h021, 32'h0), 4'b0000, 8'h08, 32'h0, 0, 32'h0000007F));
        vecs.push_back(mkv(mk(0, F3_B,  10'h023, 32'h0), 4'b0000, 8'h08, 32'h0, 0, 32'hFFFFFF80));
        vecs.push_back(mkv(mk(0, F3_BU, 10'h023, 32'h0), 4'b0000, 8'h08, 32'h0, 0, 32'h00000080));
        vecs.push_back(mkv(mk(0, F3_H,  10'h022, 32'h0), 4'b0000, 8'h08, 32'h0, 0, 32'hFFFF80FF));
        vecs.push_back(mkv(mk(0, F3_HU, 10'h022, 32'h0), 4'b0000, 8'h08, 32'h0, 0, 32'h000080FF));
        vecs.push_back(mkv(mk(0, F3_W,  10'h020, 32'h0), 4'b0000, 8'h08, 32'h0, 0, 32'h80FF7F01));
        vecs.push_back(mkv(mk(1, F3_B,  10'h031, 32'h000000AB), 4'b0010, 8'h0C, 32'hABABABAB, 0, 32'h0));
        vecs.push_back(mkv(mk(1, F3_H,  10'h032, 32'h00001234), 4'b1100, 8'h0C, 32'h12341234, 0, 32'h0));
        vecs.push_back(mkv(mk(0, F3_W,  10'h030, 32'h0), 4'b0000, 8'h0C, 32'h0, 0, 32'h1234AB00));
        vecs.push_back(mkv(mk(0, F3_H,  10'h021, 32'h0), 4'b0000, 8'h08, 32'h0, 1, 32'h0));
        vecs.push_back(mkv(mk(0, F3_W,  10'h022, 32'h0), 4'b0000, 8'h08, 32'h0, 1, 32'h0));
        vecs.push_back(mkv(mk(0, 3'b011, 10'h020, 32'h0), 4'b0000, 8'h08, 32'h0, 1, 32'h0));
        vecs.push_back(mkv(mk(1, F3_BU, 10'h020, 32'h11111111), 4'b0000, 8'h08, 32'h0, 1, 32'h0));
        vecs.push_back(mkv(mk(0, F3_W,  10'h020, 32'h0), 4'b0000, 8'h08, 32'h0, 0, 32'h80FF7F01));
        vecs.push_back(mkv(mk(0, F3_B,  10'h010, 32'h0), 4'b0000, 8'h04, 32'h0, 0, 32'hFFFFFFEF));
        vecs.push_back(mkv(mk(0, F3_H,  10'h012, 32'h0), 4'b0000, 8'h04, 32'h0, 0, 32'hFFFFDEAD));

        rst = 1'b1;
        core_req = 0; core_we = 0; core_funct3 = 0; core_addr = 0; core_wdata = 0;
        dma_req = 0; dma_we = 0; dma_funct3 = 0; dma_addr = 0; dma_wdata = 0;
        @(posedge clk);
        #1;

        // Reset holds off grants even with both requesting.
        cycle(1, 1, idle, 1, idle, 0, 32'h0);
        cycle(1, 1, idle, 1, idle, 0, 32'h0);

        // Contention straight out of reset alternates core, dma, core, dma.
        for (int i = 0; i < 4; i++) begin
            begin_cycle(0, 1, idle, 1, mk(0, F3_W, 10'h004, 32'h0), 0, 32'h0);
            check("rr_start", 72'({core_gnt, dma_gnt}), 72'((i % 2 == 0) ? 2'b10 : 2'b01));
            end_cycle();
        end

        foreach (vecs[i]) begin
            begin_cycle(0, 1, vecs[i].acc, 0, idle, vecs[i].err, vecs[i].rdata);
            check("mask_addr", 72'({mem_mask, mem_addr}), 72'({vecs[i].mask, vecs[i].maddr}));
            if (vecs[i].acc.we && !vecs[i].err)
                check("wdata", 72'(mem_wdata), 72'(vecs[i].mwdata));
            end_cycle();
        end

        // Misaligned DMA halfword store: granted, not issued, errored response.
        begin_cycle(0, 0, idle, 1, mk(1, F3_H, 10'h013, 32'h0000FFFF), 1, 32'h0);
        check("dma_sh_mis", 72'({dma_gnt, mem_cs, mem_mask}), 72'({1'b1, 1'b0, 4'b0000}));
        end_cycle();
        cycle(0, 1, mk(0, F3_W, 10'h010, 32'h0), 0, idle, 0, 32'hDEADBEEF);

        // Pointer sits on DMA after a core grant and holds through idle cycles.
        cycle(0, 1, mk(0, F3_W, 10'h020, 32'h0), 0, idle, 0, 32'h80FF7F01);
        cycle(0, 0, idle, 0, idle, 0, 32'h0);
        cycle(0, 0, idle, 0, idle, 0, 32'h0);
        begin_cycle(0, 1, idle, 1, mk(0, F3_W, 10'h010, 32'h0), 0, 32'hDEADBEEF);
        check("rr_hold", 72'({core_gnt, dma_gnt}), 72'(2'b01));
        end_cycle();
        cycle(0, 1, mk(0, F3_B, 10'h023, 32'h0), 1, idle, 0, 32'hFFFFFF80);

        // Reset right after a grant drops that response and re-favours the core.
        cycle(0, 0, idle, 1, mk(0, F3_W, 10'h010, 32'h0), 0, 32'hDEADBEEF);
        cycle(0, 1, mk(0, F3_W, 10'h010, 32'h0), 0, idle, 0, 32'hDEADBEEF);
        begin_cycle(1, 1, idle, 1, idle, 0, 32'h0);
        check("rst_drop", 72'({core_rsp_valid, core_rdata}), 72'(0));
        end_cycle();
        begin_cycle(0, 1, mk(0, F3_W, 10'h020, 32'h0), 1, idle, 0, 32'h80FF7F01);
        check("rst_prio", 72'({core_gnt, dma_gnt}), 72'(2'b10));
        end_cycle();
        cycle(0, 0, idle, 0, idle, 0, 32'h0);
        cycle(0, 0, idle, 0, idle, 0, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DW, default 32, data width; byte lanes fixed at 4.
REQ-002 SHALL have parameter MEM_SIZE_IN_KB, default 1, size of the data memory; derived BADDRW = $clog2(MEM_SIZE_IN_KB*1024) byte-address bits.
REQ-003 SHALL have port clk_i  input  1  the only clock.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports core_req_i / dma_req_i  input  1  access request, held until grant.
REQ-006 SHALL have ports core_we_i / dma_we_i  input  1  1 = store, 0 = load.
REQ-007 SHALL have ports core_funct3_i / dma_funct3_i  input  3  RV32 size/sign code (LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101).
REQ-008 SHALL have ports core_addr_i / dma_addr_i  input  BADDRW  byte address.
REQ-009 SHALL have ports core_wdata_i / dma_wdata_i  input  DW  store data, right-aligned.
REQ-010 SHALL have ports core_gnt_o / dma_gnt_o  output  1  combinational grant, same cycle as request.
REQ-011 SHALL have ports core_rsp_valid_o / dma_rsp_valid_o  output  1  one-cycle response strobe.
REQ-012 SHALL have ports core_rsp_err_o / dma_rsp_err_o  output  1  misaligned or illegal funct3.
REQ-013 SHALL have ports core_rdata_o / dma_rdata_o  output  DW  extracted, extended load data.
REQ-014 SHALL have ports mem_cs_o, mem_we_o  output  1 each  memory chip select and write enable.
REQ-015 SHALL have port mem_mask_o  output  4  byte-lane write mask.
REQ-016 SHALL have port mem_addr_o  output  BADDRW-2  word address = byte address[BADDRW-1:2].
REQ-017 SHALL have ports mem_wdata_o  output  DW  lane-shifted store data; mem_rdata_i  input  DW  combinational read word.

Function
REQ-018 At most one grant SHALL be asserted per cycle; one access is issued per cycle, back-to-back allowed.
REQ-019 Single requester SHALL be granted every cycle it requests.
REQ-020 Simultaneous requests SHALL be resolved round-robin: a priority pointer names the favoured requester and moves to the other requester after every grant.
REQ-021 Priority pointer SHALL NOT change in cycles with no grant.
REQ-022 Misaligned: halfword with addr[0]=1, word with addr[1:0]!=0; illegal: funct3 011/110/111, or 100/101 with we=1.
REQ-023 Legal granted access SHALL drive mem_cs_o=1, mem_we_o=we, mem_mask_o = 0001/0011/1111 shifted left by addr[1:0] on stores (0000 on loads), and mem_wdata_o = wdata replicated into addressed lanes.
REQ-024 Misaligned or illegal access SHALL still be granted but SHALL drive mem_cs_o=0, mem_mask_o=0000, and nothing is written.
REQ-025 No grant: mem_cs_o=0, mem_we_o=0, mem_mask_o=0000; mem_addr_o/mem_wdata_o are don't-care.
REQ-026 Load data SHALL be sampled from mem_rdata_i in the grant cycle, byte/half extracted at addr[1:0], sign-extended (000/001) or zero-extended (100/101), and registered.
REQ-027 Response SHALL appear exactly one cycle after grant on the granted requester's rsp_valid_o, for one cycle, for loads and stores alike; rdata = 0 for stores and errored accesses.
REQ-028 rsp_err_o SHALL be 1 with rsp_valid_o for misaligned/illegal accesses, else 0.
REQ-029 Requests are not cancellable: attributes SHALL be sampled only in the grant cycle.

Reset
REQ-030 In any cycle rst_i=1, all grants, mem_cs_o, mem_we_o, mem_mask_o SHALL be 0 and no access issued.
REQ-031 On the clock edge with rst_i=1, rsp_valid/err/rdata registers SHALL clear to 0 and the priority pointer SHALL reset to core; a response pending from the previous cycle is dropped.

Structure
REQ-032 Package dmem_pkg SHALL hold funct3 constants, requester enum (REQ_CORE, REQ_DMA) and lane-count constant.
REQ-033 Sub-module dmem_lane_align (combinational: mask generation, store replication, load extract/extend, misalign/illegal detect) SHALL be instantiated once on the muxed request.

Verification
REQ-034 Core SW addr 0x010 wdata 0xDEADBEEF -> mem_mask 1111, mem_addr 0x04; next cycle core_rsp_valid=1, err=0.
REQ-035 Word 0x80FF7F01 at 0x020; core LB 0x021 -> 0x0000007F; LB 0x023 -> 0xFFFFFF80; LBU 0x023 -> 0x00000080; LH 0x022 -> 0xFFFF80FF.
REQ-036 Core and DMA request together for 4 cycles after reset -> grants core, dma, core, dma; responses follow each by one cycle.
REQ-037 DMA SH addr 0x013 -> dma_gnt=1, mem_cs=0, next cycle dma_rsp_err=1, rdata 0; memory unchanged.
REQ-038 rst_i asserted the cycle after a core LW grant -> core_rsp_valid stays 0; after release, simultaneous requests grant core first.
